conv_3x3_feeder: RTL and testbench

- Initiator for the conv_3x3 compute port. Walks a feature map in a word-addressed fp16 buffer and gathers each 3x3 window with 9 single-word reads.
- Presents the window on im together with a latched 3x3 weight set on iw, then handshakes with conv_3x3 via conv_ready/conv_valid.
- Captures each om result and streams it out with backpressure.
- Sits between the on-chip feature buffer and conv_3x3 in the convolution datapath.

---
 rtl/conv_3x3_feeder_pkg.sv | 20 ++
 rtl/conv_3x3_feeder_win_addr_gen.sv | 94 +++++++++
 rtl/conv_3x3_feeder.sv | 148 ++++++++++++++
 tb/tb_conv_3x3_feeder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_3x3_feeder_pkg.sv
// Shared constants, FSM encoding and window-slot helper for the conv_3x3 feeder.
package conv_3x3_feeder_pkg;
  localparam int FP16_W = 16;
  localparam int KSIZE  = 3;
  localparam int TAPS   = KSIZE * KSIZE;
  localparam int WIN_W  = FP16_W * TAPS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CONV  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Bit offset of window slot (ky*3+kx); slot 0 sits in the top word.
  function automatic int unsigned slot_offset(input int unsigned slot);
    return (TAPS - 1 - slot) * FP16_W;
  endfunction
endpackage

// File: rtl/conv_3x3_feeder_win_addr_gen.sv
// Window/tap counters and feature-buffer address arithmetic for the feeder.
module win_addr_gen
  import conv_3x3_feeder_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 10,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              tap_adv,
  input  logic              win_adv,
  input  logic [ADDR_W-1:0] base,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic [ADDR_W-1:0] addr,
  output logic              last_tap,
  output logic              last_window
);
  localparam int PW = 2 * DIM_W + 2;
  localparam logic [1:0] KLAST = 2'(KSIZE - 1);

  logic [1:0]       kx_q, kx_d, ky_q, ky_d;
  logic [DIM_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [DIM_W-1:0] ow_m1, oh_m1;
  logic [DIM_W:0]   ox_s, oy_s;
  logic [PW-1:0]    row, col, row_off;

  always_comb begin
    // Stride is limited to 1 or 2, so the divide and multiply are shifts.
    if (STRIDE == 2) begin
      ow_m1 = (img_w - DIM_W'(KSIZE)) >> 1;
      oh_m1 = (img_h - DIM_W'(KSIZE)) >> 1;
      ox_s  = {ox_q, 1'b0};
      oy_s  = {oy_q, 1'b0};
    end else begin
      ow_m1 = img_w - DIM_W'(KSIZE);
      oh_m1 = img_h - DIM_W'(KSIZE);
      ox_s  = {1'b0, ox_q};
      oy_s  = {1'b0, oy_q};
    end
    row     = PW'(oy_s) + PW'(ky_q);
    col     = PW'(ox_s) + PW'(kx_q);
    row_off = row * PW'(img_w);
    addr    = base + ADDR_W'(row_off) + ADDR_W'(col);
    last_tap    = (kx_q == KLAST) && (ky_q == KLAST);
    last_window = (ox_q == ow_m1) && (oy_q == oh_m1);
  end

  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (clear) begin
      kx_d = '0;
      ky_d = '0;
      ox_d = '0;
      oy_d = '0;
    end else begin
      if (tap_adv) begin
        if (kx_q == KLAST) begin
          kx_d = '0;
          ky_d = (ky_q == KLAST) ? 2'd0 : ky_q + 2'd1;
        end else begin
          kx_d = kx_q + 2'd1;
        end
      end
      if (win_adv) begin
        if (ox_q == ow_m1) begin
          ox_d = '0;
          oy_d = oy_q + DIM_W'(1);
        end else begin
          ox_d = ox_q + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_q <= '0;
      ky_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      kx_q <= kx_d;
      ky_q <= ky_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end
endmodule

// File: rtl/conv_3x3_feeder.sv
// Gathers 3x3 fp16 windows from the feature buffer, hands them to conv_3x3 and
// streams the results out under backpressure.
module conv_3x3_feeder
  import conv_3x3_feeder_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 10,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [WIN_W-1:0]  w_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [FP16_W-1:0] rd_data,
  output logic [WIN_W-1:0]  im,
  output logic [WIN_W-1:0]  iw,
  output logic              conv_ready,
  input  logic              conv_valid,
  input  logic [FP16_W-1:0] om,
  output logic [FP16_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DIM_W-1:0]  img_w_q, img_w_d, img_h_q, img_h_d;
  logic [WIN_W-1:0]  iw_q, iw_d, im_q, im_d;
  logic [FP16_W-1:0] out_data_q, out_data_d;
  logic              issued_q, issued_d;
  logic              rd_vld_q, rd_vld_d;
  logic              clear, tap_adv, win_adv, last_tap, last_window;

  win_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W),
    .STRIDE (STRIDE)
  ) u_addr (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .tap_adv     (tap_adv),
    .win_adv     (win_adv),
    .base        (base_q),
    .img_w       (img_w_q),
    .img_h       (img_h_q),
    .addr        (rd_addr),
    .last_tap    (last_tap),
    .last_window (last_window)
  );

  // Handshakes: conv_ready/conv_valid and out_valid/out_ready both complete on the
  // rising edge where both are high; the initiator holds its data stable until then.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    img_w_d    = img_w_q;
    img_h_d    = img_h_q;
    iw_d       = iw_q;
    im_d       = im_q;
    out_data_d = out_data_q;
    issued_d   = issued_q;
    clear      = 1'b0;
    tap_adv    = 1'b0;
    win_adv    = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          img_w_d  = img_w;
          img_h_d  = img_h;
          iw_d     = w_in;
          clear    = 1'b1;
          issued_d = 1'b0;
          state_d  = ((img_w < DIM_W'(KSIZE)) || (img_h < DIM_W'(KSIZE))) ? DONE : FETCH;
        end
      end
      FETCH: begin
        // Nine read cycles, then one more cycle for the last word to land.
        if (!issued_q) begin
          rd_en    = 1'b1;
          tap_adv  = 1'b1;
          issued_d = last_tap;
        end else begin
          issued_d = 1'b0;
          state_d  = CONV;
        end
      end
      CONV: begin
        if (conv_valid) begin
          out_data_d = om;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          win_adv = 1'b1;
          state_d = last_window ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_vld_d = rd_en;
    if (rd_vld_q) im_d = {im_q[WIN_W-FP16_W-1:0], rd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      img_w_q    <= '0;
      img_h_q    <= '0;
      iw_q       <= '0;
      im_q       <= '0;
      out_data_q <= '0;
      issued_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      img_w_q    <= img_w_d;
      img_h_q    <= img_h_d;
      iw_q       <= iw_d;
      im_q       <= im_d;
      out_data_q <= out_data_d;
      issued_q   <= issued_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  assign im         = im_q;
  assign iw         = iw_q;
  assign out_data   = out_data_q;
  assign conv_ready = (state_q == CONV);
  assign out_valid  = (state_q == OUT);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_conv_3x3_feeder.sv
// Randomized scoreboard bench for conv_3x3_feeder: stride-1 and stride-2 instances
// share one feature memory and one set of checkers selected by sel.
module tb_conv_3x3_feeder;
  import conv_3x3_feeder_pkg::*;
  localparam int AW = 16;
  localparam int DW = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sel = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] img_w = '0, img_h = '0;
  logic [WIN_W-1:0] w_in = '0;
  logic          conv_valid = 1'b0;
  logic [15:0]   om = '0;
  logic          out_ready = 1'b1;

  logic          rd_en_a, rd_en_b, cr_a, cr_b, ov_a, ov_b, busy_a, busy_b, done_a, done_b;
  logic [AW-1:0] ra_a, ra_b;
  logic [15:0]   rd_data_a, rd_data_b, od_a, od_b;
  logic [WIN_W-1:0] im_a, im_b, iw_a, iw_b;
  logic [2:0]    st_a, st_b;

  conv_3x3_feeder #(.ADDR_W(AW), .DIM_W(DW), .STRIDE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .base_addr(base_addr), .img_w(img_w),
    .img_h(img_h), .w_in(w_in), .rd_en(rd_en_a), .rd_addr(ra_a), .rd_data(rd_data_a),
    .im(im_a), .iw(iw_a), .conv_ready(cr_a), .conv_valid(conv_valid & ~sel), .om(om),
    .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready & ~sel), .busy(busy_a),
    .done(done_a), .dbg_state(st_a));

  conv_3x3_feeder #(.ADDR_W(AW), .DIM_W(DW), .STRIDE(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .base_addr(base_addr), .img_w(img_w),
    .img_h(img_h), .w_in(w_in), .rd_en(rd_en_b), .rd_addr(ra_b), .rd_data(rd_data_b),
    .im(im_b), .iw(iw_b), .conv_ready(cr_b), .conv_valid(conv_valid & sel), .om(om),
    .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready & sel), .busy(busy_b),
    .done(done_b), .dbg_state(st_b));

  wire          rd_en      = sel ? rd_en_b : rd_en_a;
  wire [AW-1:0] rd_addr    = sel ? ra_b : ra_a;
  wire [WIN_W-1:0] im      = sel ? im_b : im_a;
  wire [WIN_W-1:0] iw      = sel ? iw_b : iw_a;
  wire          conv_ready = sel ? cr_b : cr_a;
  wire [15:0]   out_data   = sel ? od_b : od_a;
  wire          out_valid  = sel ? ov_b : ov_a;
  wire          busy       = sel ? busy_b : busy_a;
  wire          done       = sel ? done_b : done_a;
  wire [2:0]    dbg_state  = sel ? st_b : st_a;

  // feature memory, one-cycle read latency
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem[ra_a];
    if (rd_en_b) rd_data_b <= mem[ra_b];
  end

  // scoreboard
  logic [AW-1:0]    addr_q[$];
  logic [WIN_W-1:0] win_q[$];
  logic [15:0]      exp_q[$];
  logic [WIN_W-1:0] exp_iw = '0;
  int checks = 0, errors = 0;
  int read_cnt = 0, done_cnt = 0, result_cnt = 0, stall_seen = 0;
  int conv_hi = 0, conv_hi_last = 0, conv_wait = 0, conv_lat = 1;
  int stall_at = -1, stall_cnt = 0;
  logic fixed_om = 1'b0, rand_ready = 1'b0, spur = 1'b0, seen = 1'b0, held = 1'b0;
  logic [15:0] held_val = '0;

  task automatic chk(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none at %0t", name, $time);
  endtask

  // stand-in for the conv_3x3 arithmetic
  function automatic logic [15:0] conv_fn(input logic [WIN_W-1:0] a, input logic [WIN_W-1:0] b);
    logic [15:0] r;
    if (fixed_om) return 16'h5a00;
    r = 16'h1234;
    for (int i = 0; i < TAPS; i++) r = {r[14:0], r[15]} + (a[i*16 +: 16] ^ b[i*16 +: 16]) + 16'(i);
    return r;
  endfunction

  // reference model: window list straight from the output-map / address formulas
  task automatic predict(input int b, input int w, input int h, input int s, input logic [WIN_W-1:0] wt);
    int ow, oh, a;
    logic [WIN_W-1:0] win;
    if (w < 3 || h < 3) return;
    ow = (w - 3) / s + 1;
    oh = (h - 3) / s + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        win = '0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            a = (b + (oy * s + ky) * w + ox * s + kx) % 65536;
            addr_q.push_back(AW'(a));
            win[slot_offset(ky * 3 + kx) +: 16] = mem[a];
          end
        win_q.push_back(win);
        exp_q.push_back(conv_fn(win, wt));
      end
  endtask

  // monitor: reads, conv responder, result stream
  always @(negedge clk) begin
    if (!rst_n) begin
      conv_valid = 1'b0;
      seen = 1'b0;
      held = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (rd_en) begin
        read_cnt++;
        if (addr_q.size() == 0) fail_now("unexpected_read");
        else chk("rd_addr", WIN_W'(rd_addr), WIN_W'(addr_q.pop_front()));
      end
      if (conv_ready) begin
        if (!seen) begin
          seen = 1'b1;
          conv_valid = 1'b0;
          conv_wait = 0;
          conv_hi = 1;
          conv_lat = fixed_om ? 5 : int'($urandom_range(1, 6));
          if (win_q.size() == 0) fail_now("unexpected_window");
          else chk("window_im", im, win_q.pop_front());
          chk("window_iw", iw, exp_iw);
        end else begin
          conv_hi++;
          if (conv_wait >= conv_lat) begin
            conv_valid = 1'b1;
            om = conv_fn(im, iw);
          end else conv_wait++;
        end
      end else begin
        if (seen) conv_hi_last = conv_hi;
        seen = 1'b0;
        conv_valid = spur && out_valid && !out_ready;
        if (conv_valid) om = 16'hdead;
      end
      if (out_valid) begin
        if (held) chk("stall_data_hold", WIN_W'(out_data), WIN_W'(held_val));
        if (out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else chk("out_data", WIN_W'(out_data), WIN_W'(exp_q.pop_front()));
          result_cnt++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_val = out_data;
          stall_seen++;
          chk("stall_no_read", WIN_W'(rd_en), WIN_W'(0));
        end
      end
    end
  end

  // out_ready driver
  always @(posedge clk) begin
    #1;
    if (stall_at >= 0 && result_cnt == stall_at && out_valid && stall_cnt < 20) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic issue_start(input int b, input int w, input int h, input logic [WIN_W-1:0] wt);
    @(posedge clk) #1;
    base_addr = AW'(b);
    img_w = DW'(w);
    img_h = DW'(h);
    w_in = wt;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    img_w = DW'($urandom);
    img_h = DW'($urandom);
    for (int i = 0; i < TAPS; i++) w_in[i*16 +: 16] = 16'($urandom);
  endtask

  task automatic run_pass(input int b, input int w, input int h, input logic [WIN_W-1:0] wt,
                          input int exp_res, output int cyc);
    int r0, d0;
    predict(b, w, h, sel ? 2 : 1, wt);
    exp_iw = wt;
    r0 = result_cnt;
    d0 = done_cnt;
    issue_start(b, w, h, wt);
    chk("busy_after_start", WIN_W'(busy), WIN_W'(1));
    cyc = 0;
    while (done_cnt == d0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 5000) fail_now("pass_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("result_count", WIN_W'(result_cnt - r0), WIN_W'(exp_res));
    chk("done_pulses", WIN_W'(done_cnt - d0), WIN_W'(1));
    chk("queues_drained", WIN_W'(addr_q.size() + win_q.size() + exp_q.size()), WIN_W'(0));
    chk("busy_after_done", WIN_W'(busy), WIN_W'(0));
  endtask

  function automatic logic [WIN_W-1:0] rand_w();
    logic [WIN_W-1:0] r;
    for (int i = 0; i < TAPS; i++) r[i*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  initial begin
    logic [15:0] ones [0:8];
    logic [WIN_W-1:0] wp;
    int cyc, r0, w, h;
    ones = '{16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_en", WIN_W'(rd_en), WIN_W'(0));
    chk("reset_rd_addr", WIN_W'(rd_addr), WIN_W'(0));
    chk("reset_im", im, '0);
    chk("reset_iw", iw, '0);
    chk("reset_conv_ready", WIN_W'(conv_ready), WIN_W'(0));
    chk("reset_out", WIN_W'({out_valid, out_data}), WIN_W'(0));
    chk("reset_busy_done", WIN_W'({busy, done}), WIN_W'(0));
    chk("reset_state", WIN_W'(dbg_state), WIN_W'(IDLE));
    rst_n = 1'b1;

    // 3x3 image of 1.0..9.0, fixed conv result and 5-cycle latency
    wp = '0;
    for (int i = 0; i < 9; i++) begin
      mem[16'h0100 + i] = ones[i];
      wp[slot_offset(i) +: 16] = ones[i];
    end
    fixed_om = 1'b1;
    run_pass(16'h0100, 3, 3, wp, 1, cyc);
    chk("conv_ready_hold", WIN_W'(conv_hi_last >= 5), WIN_W'(1));
    fixed_om = 1'b0;

    // 5x4 stride 1 and 6x6 stride 2 from base 0
    run_pass(0, 5, 4, rand_w(), 6, cyc);
    sel = 1'b1;
    run_pass(0, 6, 6, rand_w(), 4, cyc);
    sel = 1'b0;

    // 20-cycle stall on result 2, with spurious conv_valid while stalled
    spur = 1'b1;
    stall_cnt = 0;
    stall_at = result_cnt + 2;
    r0 = stall_seen;
    run_pass(7, 5, 5, rand_w(), 9, cyc);
    chk("stall_length", WIN_W'(stall_seen - r0 >= 20), WIN_W'(1));
    stall_at = -1;
    spur = 1'b0;

    // too-narrow image, then a start pulse ignored during a busy 4x4 pass
    run_pass(16'h0200, 2, 5, rand_w(), 0, cyc);
    chk("short_pass_latency", WIN_W'(cyc <= 2), WIN_W'(1));
    fork
      run_pass(16'h0300, 4, 4, rand_w(), 4, cyc);
      begin
        repeat (30) @(posedge clk);
        #1;
        base_addr = 16'h7777;
        img_w = 10'd9;
        img_h = 10'd9;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
      end
    join

    // reset while tap 4 is on the read port, then a clean pass
    wp = rand_w();
    predict(16'h0400, 5, 5, 1, wp);
    exp_iw = wp;
    r0 = read_cnt;
    issue_start(16'h0400, 5, 5, wp);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reads_before_reset", WIN_W'(read_cnt - r0), WIN_W'(4));
    chk("mid_reset_rd", WIN_W'({rd_en, rd_addr}), WIN_W'(0));
    chk("mid_reset_im_iw", im | iw, '0);
    chk("mid_reset_ctrl", WIN_W'({conv_ready, out_valid, out_data, busy, done}), WIN_W'(0));
    addr_q.delete();
    win_q.delete();
    exp_q.delete();
    @(posedge clk) #1;
    rst_n = 1'b1;
    run_pass(16'h0400, 5, 5, rand_w(), 9, cyc);

    // randomized passes with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      sel = 1'($urandom_range(0, 1));
      w = int'($urandom_range(3, 8));
      h = int'($urandom_range(3, 6));
      run_pass((n == 2) ? 16'hfff8 : int'($urandom_range(0, 65535)), w, h, rand_w(),
               ((w - 3) / (sel ? 2 : 1) + 1) * ((h - 3) / (sel ? 2 : 1) + 1), cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
